seq_comparator: RTL and testbench

Parametrised, multi-cycle magnitude comparator; successor to the team's fixed 8-bit combinational comparator.
- Accepts two WIDTH-bit operands over a valid/ready handshake.
- Compares them CHUNK bits per cycle, MSB chunk first, in signed or unsigned mode.
- Returns a one-hot greater/equal/less result over a second valid/ready handshake.
- Used where wide operands make a single-cycle compare too slow for timing.

---
 rtl/seq_cmp_pkg.sv | 21 ++
 rtl/seq_comparator_chunk_compare.sv | 28 ++
 rtl/seq_comparator.sv | 132 +++++++++++++
 tb/tb_seq_comparator.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seq_cmp_pkg.sv
// Shared types and sizing helper for the multi-cycle magnitude comparator.
package seq_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_GT,
    RES_EQ,
    RES_LT
  } cmp_res_t;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/seq_comparator_chunk_compare.sv
// Combinational CHUNK-wide unsigned compare; invert_msb flips both MSBs so the
// signed top chunk orders correctly under an unsigned compare. Zero latency.
module chunk_compare #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             invert_msb,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  logic [CHUNK-1:0] msb_mask;
  logic [CHUNK-1:0] a_m;
  logic [CHUNK-1:0] b_m;

  always_comb begin
    msb_mask            = '0;
    msb_mask[CHUNK-1]   = invert_msb;
    a_m                 = a ^ msb_mask;
    b_m                 = b ^ msb_mask;
    gt                  = (a_m > b_m);
    eq                  = (a_m == b_m);
    lt                  = (a_m < b_m);
  end

endmodule

// File: rtl/seq_comparator.sv
// Multi-cycle signed/unsigned comparator, MSB chunk first; 1..NCHUNK edges to a held
// result (SEQ_CMP_EARLY_EXIT_EN), NCHUNK otherwise; in_ready only in IDLE, result held until out_ready.
module seq_comparator
  import seq_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_greater,
  output logic             a_equal,
  output logic             a_less
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NCHUNK - 1);

`ifdef SEQ_CMP_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  generate
    if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_param_check
      $fatal(1, "seq_comparator: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  state_t           state_q, state_d;
  cmp_res_t         res_q, res_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q;
  logic             load;

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             c_gt, c_eq, c_lt;
  cmp_res_t         chunk_res;

  always_comb begin
    a_chunk = a_q[int'(idx_q)*CHUNK +: CHUNK];
    b_chunk = b_q[int'(idx_q)*CHUNK +: CHUNK];
  end

  chunk_compare #(.CHUNK(CHUNK)) u_chunk_compare (
    .a          (a_chunk),
    .b          (b_chunk),
    .invert_msb (sgn_q && (idx_q == TOP_IDX)),
    .gt         (c_gt),
    .eq         (c_eq),
    .lt         (c_lt)
  );

  always_comb begin
    chunk_res = RES_EQ;
    if (c_gt)      chunk_res = RES_GT;
    else if (c_lt) chunk_res = RES_LT;
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    idx_d   = idx_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          idx_d   = TOP_IDX;
          res_d   = RES_NONE;
          state_d = CMP;
        end
      end
      CMP: begin
        // Only the first differing chunk may set the decision; later chunks never overwrite it.
        if (res_q == RES_NONE && !c_eq) res_d = chunk_res;
        if (EARLY_EXIT && !c_eq) begin
          state_d = DONE;
        end else if (idx_q == '0) begin
          if (res_q == RES_NONE) res_d = chunk_res;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          res_d   = RES_NONE;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= RES_NONE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      if (load) begin
        a_q   <= a;
        b_q   <= b;
        sgn_q <= signed_mode;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign a_greater = out_valid && (res_q == RES_GT);
  assign a_equal   = out_valid && (res_q == RES_EQ);
  assign a_less    = out_valid && (res_q == RES_LT);

endmodule

// File: tb/tb_seq_comparator.sv
// Directed bench for seq_comparator (WIDTH=32, CHUNK=8): vector table plus backpressure and reset-abort sequences.
module tb_seq_comparator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        signed_mode;
  logic        out_valid;
  logic        out_ready;
  logic        a_greater;
  logic        a_equal;
  logic        a_less;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_comparator #(.WIDTH(32), .CHUNK(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .a_greater   (a_greater),
    .a_equal     (a_equal),
    .a_less      (a_less)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [2:0]  flags;     // {gt, eq, lt}
    int          lat_early; // chunks examined with early exit
  } vec_t;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic int exp_lat(input int lat_early);
`ifdef SEQ_CMP_EARLY_EXIT_EN
    return lat_early;
`else
    return 4 + 0 * lat_early;
`endif
  endfunction

  // Waits for out_valid (edges counted from the accept edge), bounded at 20 edges.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] va, input logic [31:0] vb,
                        input logic sgn, input logic [2:0] flags, input int lat_early);
    int lat;
    @(negedge clk);
    chk({name, " in_ready"}, 32'(in_ready), 32'd1);
    a = va; b = vb; signed_mode = sgn; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = ~va; b = ~vb;
    wait_result(lat);
    chk({name, " latency"}, 32'(lat), 32'(exp_lat(lat_early)));
    chk({name, " flags"}, 32'({a_greater, a_equal, a_less}), 32'(flags));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, " idle after pop"}, 32'({in_ready, out_valid, a_greater, a_equal, a_less}), 32'b10000);
  endtask

  vec_t vecs[12];

  initial begin
    int lat;
    int seen;

    vecs[0]  = '{32'h12345678, 32'h12345678, 1'b0, EQ, 4};
    vecs[1]  = '{32'hFF000000, 32'h01000000, 1'b0, GT, 1};
    vecs[2]  = '{32'hFFFFFFFF, 32'h00000001, 1'b1, LT, 1};
    vecs[3]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, GT, 1};
    vecs[4]  = '{32'h80000000, 32'h7FFFFFFF, 1'b1, LT, 1};
    vecs[5]  = '{32'h00000001, 32'h00000002, 1'b0, LT, 4};
    vecs[6]  = '{32'h12340000, 32'h12FF0000, 1'b0, LT, 2};
    vecs[7]  = '{32'h00AB0000, 32'h00AA00FF, 1'b0, GT, 2};
    vecs[8]  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, LT, 4};
    vecs[9]  = '{32'h7FFFFFFF, 32'h80000000, 1'b1, GT, 1};
    vecs[10] = '{32'h00000000, 32'h00000000, 1'b1, EQ, 4};
    vecs[11] = '{32'h80000000, 32'h80000000, 1'b1, EQ, 4};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; signed_mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset state", 32'({in_ready, out_valid, a_greater, a_equal, a_less}), 32'b10000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset state", 32'({in_ready, out_valid, a_greater, a_equal, a_less}), 32'b10000);

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].flags,
             vecs[i].lat_early);
    end

    // Result backpressure with new operands offered while DONE
    @(negedge clk);
    a = 32'hFF000000; b = 32'h01000000; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(lat);
    chk("bp first result valid", 32'(out_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      a = 32'h00000000; b = 32'h00000001; signed_mode = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp hold cycle%0d", c),
          32'({in_ready, out_valid, a_greater, a_equal, a_less}), 32'b01100);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp idle bubble", 32'({in_ready, out_valid, a_greater, a_equal, a_less}), 32'b10000);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp new op accepted", 32'(in_ready), 32'd0);
    wait_result(lat);
    chk("bp new op latency", 32'(lat), 32'(exp_lat(4)));
    chk("bp new op flags", 32'({a_greater, a_equal, a_less}), 32'(LT));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during CMP aborts the operation
    a = 32'h00000001; b = 32'h00000002; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort in CMP", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort reset state", 32'({in_ready, out_valid, a_greater, a_equal, a_less}), 32'b10000);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort no result", 32'(seen), 32'd0);
    run_op("after abort", 32'd5, 32'd3, 1'b0, GT, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
